// File: rtl/accel_bus_slave_if.sv
// Handshake signals between the CPU accelerator port and the accelerator
// endpoint. The shared data bus is a separate inout port on the endpoint.
interface accel_bus_slave_if;
  logic       bus_en;
  logic       bus_start;
  logic [1:0] bus_rdwr;
  logic [2:0] bus_regaddr;
  logic       bus_done;

  modport master (
    output bus_en, bus_start, bus_rdwr, bus_regaddr,
    input  bus_done
  );

  modport slave (
    input  bus_en, bus_start, bus_rdwr, bus_regaddr,
    output bus_done
  );
endinterface

// File: rtl/accel_bus_slave.sv
// Accelerator bus endpoint: configuration/status register file, register
// read/write over the shared tristate bus, and run launch with a cycle
// counter and timeout guard. bus_done is held until the CPU drops bus_en.
module accel_bus_slave #(
  parameter logic [15:0] TIMEOUT = 16'd1024
) (
  input  logic               clk,
  input  logic               rst,
  accel_bus_slave_if.slave   bus,
  inout  wire  [15:0]        bus_data,
  output logic [95:0]        acc_cfg,
  output logic               acc_start,
  input  logic               acc_done,
  output logic               acc_abort
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RUN,
    ST_ACK
  } state_t;

  state_t      state_q;
  logic [15:0] cfg_q [6];
  logic        err_q;
  logic [15:0] cycles_q;
  logic [15:0] cnt_q;
  logic [15:0] rdata_q;
  logic        rd_op_q;
  logic        done_q;
  logic        start_q;
  logic        abort_q;

  logic [15:0] rd_mux_d;
  logic [15:0] cnt_inc_d;

  // Read mux over the full register map, addressed by the bus register index.
  always_comb begin
    rd_mux_d = '0;
    case (bus.bus_regaddr)
      3'd6:    rd_mux_d = {14'd0, err_q, state_q == ST_RUN};
      3'd7:    rd_mux_d = cycles_q;
      default: begin
        for (int unsigned i = 0; i < 6; i++) begin
          if (bus.bus_regaddr == 3'(i)) rd_mux_d = cfg_q[i];
        end
      end
    endcase
  end

  // Run counter next value, saturating at all-ones.
  always_comb begin
    cnt_inc_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  end

  // Flatten CFG registers onto the accelerator configuration port, reg0 lowest.
  always_comb begin
    acc_cfg = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      acc_cfg[i*16 +: 16] = cfg_q[i];
    end
  end

  // Transaction FSM with registered bus_done, acc_start and acc_abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cfg_q    <= '{default: '0};
      err_q    <= 1'b0;
      cycles_q <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rd_op_q  <= 1'b0;
      done_q   <= 1'b0;
      start_q  <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      abort_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.bus_en) begin
            rd_op_q <= 1'b0;
            if (bus.bus_start) begin
              state_q <= ST_RUN;
              cnt_q   <= '0;
              start_q <= 1'b1;
            end else if (bus.bus_rdwr == 2'b10) begin
              state_q <= ST_READ;
            end else if (bus.bus_rdwr == 2'b01) begin
              state_q <= ST_WRITE;
            end else begin
              state_q <= ST_ACK;
              done_q  <= 1'b1;
            end
          end
        end
        ST_READ: begin
          rdata_q <= rd_mux_d;
          rd_op_q <= 1'b1;
          done_q  <= 1'b1;
          state_q <= ST_ACK;
        end
        ST_WRITE: begin
          for (int unsigned i = 0; i < 6; i++) begin
            if (bus.bus_regaddr == 3'(i)) cfg_q[i] <= bus_data;
          end
          if (bus.bus_regaddr == 3'd6) err_q <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_ACK;
        end
        ST_RUN: begin
          cnt_q <= cnt_inc_d;
          // Completion is checked first so a done on the timeout cycle wins.
          if (acc_done) begin
            cycles_q <= cnt_inc_d;
            done_q   <= 1'b1;
            state_q  <= ST_ACK;
          end else if (cnt_inc_d == TIMEOUT) begin
            cycles_q <= TIMEOUT;
            err_q    <= 1'b1;
            abort_q  <= 1'b1;
            done_q   <= 1'b1;
            state_q  <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (!bus.bus_en) begin
            done_q  <= 1'b0;
            rd_op_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.bus_done = done_q;
  assign acc_start    = start_q;
  assign acc_abort    = abort_q;
  assign bus_data     = (state_q == ST_ACK && rd_op_q) ? rdata_q : 'z;

endmodule

// File: tb/tb_accel_bus_slave.sv
// Self-checking bench for accel_bus_slave: a register/run model produces
// expected read data, which is queued at request time and compared when
// the endpoint acknowledges the read.
module tb_accel_bus_slave;
  localparam int TO = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_oe;
  logic [15:0] cpu_wdata;
  wire  [15:0] bus_data;
  logic [95:0] acc_cfg;
  logic        acc_start;
  logic        acc_done;
  logic        acc_abort;

  always #5 clk = ~clk;

  accel_bus_slave_if bus_if ();

  assign bus_data = cpu_oe ? cpu_wdata : 'z;

  accel_bus_slave #(.TIMEOUT(16'(TO))) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .bus_data  (bus_data),
    .acc_cfg   (acc_cfg),
    .acc_start (acc_start),
    .acc_done  (acc_done),
    .acc_abort (acc_abort)
  );

  int n_chk = 0;
  int n_fail = 0;
  int start_cnt = 0;
  int abort_cnt = 0;

  logic [15:0] m_cfg [6];
  logic        m_err;
  logic [15:0] m_cycles;
  logic [15:0] sb [$];

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (acc_start) start_cnt++;
    if (acc_abort) abort_cnt++;
  end

  task automatic check_val(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] m_cfg_flat();
    logic [95:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) r[i*16 +: 16] = m_cfg[i];
    return r;
  endfunction

  function automatic logic [15:0] m_reg(input int a);
    if (a < 6) return m_cfg[a];
    if (a == 6) return {14'd0, m_err, 1'b0};
    return m_cycles;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_cfg[i] = '0;
    m_err = 1'b0;
    m_cycles = '0;
  endtask

  task automatic req(input logic [1:0] rdwr, input int addr, input logic [15:0] wd, input logic start);
    bus_if.bus_en      = 1'b1;
    bus_if.bus_start   = start;
    bus_if.bus_rdwr    = rdwr;
    bus_if.bus_regaddr = 3'(addr);
    cpu_oe    = (!start && rdwr == 2'b01);
    cpu_wdata = wd;
    if (!start) begin
      if (rdwr == 2'b10) sb.push_back(m_reg(addr));
      else if (rdwr == 2'b01) begin
        if (addr < 6) m_cfg[addr] = wd;
        else if (addr == 6) m_err = 1'b0;
      end
    end
  endtask

  task automatic wait_done(input int exp_lat, input logic is_read);
    int lat;
    logic [15:0] exp;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus_if.bus_done && lat < 64);
    check_val("done_latency", 96'(lat), 96'(exp_lat));
    if (is_read) begin
      exp = sb.pop_front();
      check_val("read_data", 96'(bus_data), 96'(exp));
    end
  endtask

  task automatic check_released(input string tag);
    cpu_oe = 1'b1;
    cpu_wdata = 16'h5A5A;
    #1;
    check_val(tag, 96'(bus_data), 96'(16'h5A5A));
    cpu_oe = 1'b0;
  endtask

  task automatic release_bus(input int hold, input logic is_read);
    if (!is_read) check_released("ack_bus_released");
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_val("done_hold", 96'(bus_if.bus_done), 96'(1));
    end
    bus_if.bus_en = 1'b0;
    bus_if.bus_start = 1'b0;
    @(posedge clk); #1;
    check_val("done_drop", 96'(bus_if.bus_done), 96'(0));
  endtask

  task automatic do_write(input int addr, input logic [15:0] wd);
    req(2'b01, addr, wd, 1'b0);
    wait_done(2, 1'b0);
    release_bus(0, 1'b0);
    check_val("acc_cfg_after_wr", acc_cfg, m_cfg_flat());
  endtask

  task automatic do_read(input int addr);
    req(2'b10, addr, 16'h0, 1'b0);
    wait_done(2, 1'b1);
    release_bus(0, 1'b1);
  endtask

  // done_at: RUN cycle (1 = acc_start cycle) in which acc_done is driven; 0 = never.
  task automatic run_op(input int done_at);
    int n, s0, a0, exp_len;
    logic exp_abort;
    exp_abort = !(done_at > 0 && done_at <= TO);
    exp_len = exp_abort ? TO : done_at;
    s0 = start_cnt;
    a0 = abort_cnt;
    req(2'b10, 0, 16'h0, 1'b1);
    @(posedge clk); #1;
    check_val("start_pulse", 96'(acc_start), 96'(1));
    n = 1;
    while (!bus_if.bus_done && n < TO + 8) begin
      acc_done = (n == done_at);
      @(posedge clk); #1;
      acc_done = 1'b0;
      if (!bus_if.bus_done) n++;
    end
    check_val("run_len", 96'(n), 96'(exp_len));
    check_val("abort_at_ack", 96'(acc_abort), 96'(exp_abort));
    m_cycles = 16'(exp_len);
    if (exp_abort) m_err = 1'b1;
    release_bus(0, 1'b0);
    check_val("start_once", 96'(start_cnt - s0), 96'(1));
    check_val("abort_count", 96'(abort_cnt - a0), 96'(exp_abort));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    rst = 1'b1;
    cpu_oe = 1'b0;
    cpu_wdata = '0;
    acc_done = 1'b0;
    bus_if.bus_en = 1'b0;
    bus_if.bus_start = 1'b0;
    bus_if.bus_rdwr = 2'b00;
    bus_if.bus_regaddr = 3'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_bus_done", 96'(bus_if.bus_done), 96'(0));
    check_val("rst_acc_start", 96'(acc_start), 96'(0));
    check_val("rst_acc_abort", 96'(acc_abort), 96'(0));
    check_val("rst_acc_cfg", acc_cfg, 96'(0));
    check_released("rst_bus_released");
    rst = 1'b0;
    @(posedge clk); #1;

    do_read(6);
    do_read(7);

    // Basic write/read and CFG visibility.
    do_write(3, 16'hBEEF);
    do_read(3);
    check_val("acc_cfg_reg3", 96'(acc_cfg[63:48]), 96'(16'hBEEF));
    for (int i = 0; i < 6; i++) do_write(i, 16'(16'h1111 * (i + 1) + 16'h0100));
    for (int i = 0; i < 8; i++) do_read(i);

    // Run completing on RUN cycle 10.
    run_op(10);
    do_read(6);
    do_read(7);

    // Timeout, then clear the sticky error.
    run_op(0);
    do_read(6);
    do_read(7);
    do_write(6, 16'h0000);
    do_read(6);

    // Completion on exactly the timeout cycle.
    run_op(TO);
    do_read(6);
    do_read(7);

    // Shortest run.
    run_op(1);
    do_read(7);

    // CYCLES write ignored, no-op with extended hold.
    do_write(7, 16'h1234);
    do_read(7);
    req(2'b11, 2, 16'h0, 1'b0);
    wait_done(1, 1'b0);
    release_bus(5, 1'b0);
    check_val("noop_acc_cfg", acc_cfg, m_cfg_flat());
    do_read(7);
    do_read(2);

    // acc_done outside RUN has no effect.
    acc_done = 1'b1;
    @(posedge clk); #1;
    acc_done = 1'b0;
    do_read(7);
    do_read(6);

    // Reset in the middle of a run.
    a0 = abort_cnt;
    req(2'b00, 0, 16'h0, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("rstrun_bus_done", 96'(bus_if.bus_done), 96'(0));
    check_val("rstrun_acc_start", 96'(acc_start), 96'(0));
    check_val("rstrun_acc_abort", 96'(acc_abort), 96'(0));
    check_val("rstrun_acc_cfg", acc_cfg, 96'(0));
    rst = 1'b0;
    bus_if.bus_en = 1'b0;
    bus_if.bus_start = 1'b0;
    model_reset();
    check_released("rstrun_bus_released");
    repeat (40) @(posedge clk);
    #1;
    check_val("rstrun_no_abort", 96'(abort_cnt - a0), 96'(0));
    do_read(7);
    do_read(4);

    // Reset during the ACK of a read, with bus_en still held.
    do_write(3, 16'hBEEF);
    req(2'b10, 3, 16'h0, 1'b0);
    wait_done(2, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("rstack_bus_done", 96'(bus_if.bus_done), 96'(0));
    check_val("rstack_acc_cfg", acc_cfg, 96'(0));
    check_val("rstack_acc_abort", 96'(acc_abort), 96'(0));
    rst = 1'b0;
    bus_if.bus_en = 1'b0;
    model_reset();
    check_released("rstack_bus_released");
    @(posedge clk); #1;
    do_read(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
